// File: rtl/expression_parser_pkg.sv
// Shared types and ASCII/operator constants for the expression parser and
// the processing unit's operator decode.
package expression_parser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ACC_W  = 10;

  // Parser FSM states
  typedef enum logic [2:0] {
    IDLE,
    OPA,
    OPB_START,
    OPB,
    ISSUE,
    FLUSH
  } parser_state_t;

  // Input byte classification
  typedef enum logic [2:0] {
    CLS_DIGIT,
    CLS_OPER,
    CLS_TERM,
    CLS_SPACE,
    CLS_INVALID
  } char_class_t;

  // Parsed expression as handed to the processing unit
  typedef struct packed {
    logic [BYTE_W-1:0] operation;
    logic [BYTE_W-1:0] data_b;
    logic [BYTE_W-1:0] data_a;
  } expr_t;

  localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_NINE  = 8'h39;
  localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_EQ    = 8'h3D;
  localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;

  localparam logic [BYTE_W-1:0] OP_ADD = 8'h2B;
  localparam logic [BYTE_W-1:0] OP_SUB = 8'h2D;
  localparam logic [BYTE_W-1:0] OP_MUL = 8'h2A;
  localparam logic [BYTE_W-1:0] OP_DIV = 8'h2F;
  localparam logic [BYTE_W-1:0] OP_AND = 8'h26;
  localparam logic [BYTE_W-1:0] OP_OR  = 8'h7C;

  // Map one ASCII byte onto its syntactic class
  function automatic char_class_t classify(input logic [BYTE_W-1:0] c);
    char_class_t cls;
    cls = CLS_INVALID;
    if ((c >= ASCII_ZERO) && (c <= ASCII_NINE)) begin
      cls = CLS_DIGIT;
    end else if ((c == OP_ADD) || (c == OP_SUB) || (c == OP_MUL) ||
                 (c == OP_DIV) || (c == OP_AND) || (c == OP_OR)) begin
      cls = CLS_OPER;
    end else if ((c == ASCII_EQ) || (c == ASCII_CR)) begin
      cls = CLS_TERM;
    end else if (c == ASCII_SPACE) begin
      cls = CLS_SPACE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/expression_parser_if.sv
// Byte-stream input and parsed-expression output bundle of the parser.
interface expression_parser_if;
  import expression_parser_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [BYTE_W-1:0] data_a;
  logic [BYTE_W-1:0] data_b;
  logic [BYTE_W-1:0] operation;
  logic              op_valid;
  logic              parse_error;
  logic              busy;

  // Byte source / result consumer side
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, data_a, data_b, operation, op_valid, parse_error, busy
  );

  // Parser side
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, data_a, data_b, operation, op_valid, parse_error, busy
  );

endinterface

// File: rtl/expression_parser_decimal_accumulator.sv
// Decimal operand accumulator: value = value*10 + digit, with a look-ahead
// flag telling whether the presented digit would break the range rules.
module expression_parser_decimal_accumulator
  import expression_parser_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_load_digit,
  input  logic [3:0]       i_digit,
  output logic [ACC_W-1:0] o_value,
  output logic [CNT_W-1:0] o_digit_count,
  output logic             o_overflow_c
);

  localparam int unsigned WIDE_W = ACC_W + 4;

  logic [ACC_W-1:0]  r_value;
  logic [CNT_W-1:0]  r_count;
  logic [ACC_W-1:0]  w_base_value;
  logic [CNT_W-1:0]  w_base_count;
  logic [WIDE_W-1:0] w_next_value;
  logic [CNT_W:0]    w_next_count;

  // Candidate value/count if i_digit were loaded now; clear starts a fresh operand
  always_comb begin
    w_base_value = i_clear ? '0 : r_value;
    w_base_count = i_clear ? '0 : r_count;
    w_next_value = WIDE_W'(w_base_value) * WIDE_W'(10) + WIDE_W'(i_digit);
    w_next_count = (CNT_W + 1)'(w_base_count) + (CNT_W + 1)'(1);
    o_overflow_c = (w_next_value > WIDE_W'(255)) ||
                   (w_next_count > (CNT_W + 1)'(MAX_DIGITS));
  end

  // Accumulator and digit counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_load_digit) begin
      r_value <= ACC_W'(w_next_value);
      r_count <= CNT_W'(w_next_count);
    end else if (i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end
  end

  assign o_value       = r_value;
  assign o_digit_count = r_count;

endmodule

// File: rtl/expression_parser.sv
// ASCII "<A><op><B>=" stream parser feeding the arithmetic processing unit.
// Optional build macro EXPRESSION_PARSER_TIMEOUT_EN adds a mid-expression
// idle timeout that aborts the partial parse back to IDLE.
module expression_parser
  import expression_parser_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 3
`ifdef EXPRESSION_PARSER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 50_000_000
`endif
) (
  input logic                clock,
  input logic                reset,
  expression_parser_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 2);

  parser_state_t     r_state;
  parser_state_t     w_state_nxt;
  expr_t             r_expr;
  logic [BYTE_W-1:0] r_operator;
  logic              r_rx_ready;
  logic              r_op_valid;
  logic              r_parse_error;
  logic              r_busy;

  char_class_t       w_class;
  logic              w_fire;
  logic [3:0]        w_digit;
  logic              w_clear_a;
  logic              w_clear_b;
  logic              w_load_a;
  logic              w_load_b;
  logic              w_store_op;
  logic              w_issue;
  logic              w_error;
  logic              w_timeout;
  logic              w_operands_ok;
  logic [ACC_W-1:0]  w_value_a;
  logic [ACC_W-1:0]  w_value_b;
  logic [CNT_W-1:0]  w_count_a;
  logic [CNT_W-1:0]  w_count_b;
  logic              w_ovf_a;
  logic              w_ovf_b;

  assign w_fire  = bus.rx_valid && r_rx_ready;
  assign w_class = classify(bus.rx_data);
  assign w_digit = bus.rx_data[3:0];

  // First digit of an operand restarts its accumulator
  assign w_clear_a = (r_state == IDLE)      && w_fire && (w_class == CLS_DIGIT);
  assign w_clear_b = (r_state == OPB_START) && w_fire && (w_class == CLS_DIGIT);

  // Loads are range-guarded, so this only guards against truncation at issue
  assign w_operands_ok = (w_value_a[ACC_W-1:8] == '0) && (w_value_b[ACC_W-1:8] == '0) &&
                         (w_count_a != '0) && (w_count_b != '0);

  expression_parser_decimal_accumulator #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_acc_a (
    .clock         (clock),
    .reset         (reset),
    .i_clear       (w_clear_a),
    .i_load_digit  (w_load_a),
    .i_digit       (w_digit),
    .o_value       (w_value_a),
    .o_digit_count (w_count_a),
    .o_overflow_c  (w_ovf_a)
  );

  expression_parser_decimal_accumulator #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_acc_b (
    .clock         (clock),
    .reset         (reset),
    .i_clear       (w_clear_b),
    .i_load_digit  (w_load_b),
    .i_digit       (w_digit),
    .o_value       (w_value_b),
    .o_digit_count (w_count_b),
    .o_overflow_c  (w_ovf_b)
  );

`ifdef EXPRESSION_PARSER_TIMEOUT_EN
  localparam int unsigned TIMER_W = 26;

  logic [TIMER_W-1:0] r_timer;
  logic               w_mid;

  assign w_mid     = (r_state == OPA) || (r_state == OPB_START) || (r_state == OPB);
  assign w_timeout = w_mid && !w_fire && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter; restarts on every accepted byte and outside an expression
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (w_fire || !w_mid) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Parser state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-byte actions
  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_store_op  = 1'b0;
    w_issue     = 1'b0;
    w_error     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fire) begin
          case (w_class)
            CLS_DIGIT: begin
              w_load_a    = 1'b1;
              w_state_nxt = OPA;
            end
            CLS_TERM, CLS_SPACE: begin
            end
            default: begin
              w_error     = 1'b1;
              w_state_nxt = FLUSH;
            end
          endcase
        end
      end

      OPA: begin
        if (w_fire) begin
          case (w_class)
            CLS_DIGIT: begin
              if (w_ovf_a) begin
                w_error     = 1'b1;
                w_state_nxt = FLUSH;
              end else begin
                w_load_a = 1'b1;
              end
            end
            CLS_OPER: begin
              w_store_op  = 1'b1;
              w_state_nxt = OPB_START;
            end
            CLS_TERM: begin
              w_error     = 1'b1;
              w_state_nxt = IDLE;
            end
            CLS_SPACE: begin
            end
            default: begin
              w_error     = 1'b1;
              w_state_nxt = FLUSH;
            end
          endcase
        end
      end

      OPB_START: begin
        if (w_fire) begin
          case (w_class)
            CLS_DIGIT: begin
              w_load_b    = 1'b1;
              w_state_nxt = OPB;
            end
            CLS_TERM: begin
              w_error     = 1'b1;
              w_state_nxt = IDLE;
            end
            CLS_SPACE: begin
            end
            default: begin
              w_error     = 1'b1;
              w_state_nxt = FLUSH;
            end
          endcase
        end
      end

      OPB: begin
        if (w_fire) begin
          case (w_class)
            CLS_DIGIT: begin
              if (w_ovf_b) begin
                w_error     = 1'b1;
                w_state_nxt = FLUSH;
              end else begin
                w_load_b = 1'b1;
              end
            end
            CLS_TERM: begin
              if (w_operands_ok) begin
                w_issue     = 1'b1;
                w_state_nxt = ISSUE;
              end else begin
                w_error     = 1'b1;
                w_state_nxt = IDLE;
              end
            end
            CLS_SPACE: begin
            end
            default: begin
              w_error     = 1'b1;
              w_state_nxt = FLUSH;
            end
          endcase
        end
      end

      ISSUE: begin
        w_state_nxt = IDLE;
      end

      FLUSH: begin
        if (w_fire && (w_class == CLS_TERM)) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Timeout only fires when no byte arrives, so it never races an action above
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_error     = 1'b1;
    end
  end

  // Registered outputs, operator latch and result register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_ready    <= 1'b1;
      r_op_valid    <= 1'b0;
      r_parse_error <= 1'b0;
      r_busy        <= 1'b0;
      r_operator    <= '0;
      r_expr        <= '0;
    end else begin
      r_rx_ready    <= (w_state_nxt != ISSUE);
      r_op_valid    <= w_issue;
      r_parse_error <= w_error;
      r_busy        <= (w_state_nxt != IDLE);
      if (w_store_op) begin
        r_operator <= bus.rx_data;
      end
      if (w_issue) begin
        r_expr <= '{operation: r_operator,
                    data_b:    w_value_b[BYTE_W-1:0],
                    data_a:    w_value_a[BYTE_W-1:0]};
      end
    end
  end

  assign bus.rx_ready    = r_rx_ready;
  assign bus.op_valid    = r_op_valid;
  assign bus.parse_error = r_parse_error;
  assign bus.busy        = r_busy;
  assign bus.data_a      = r_expr.data_a;
  assign bus.data_b      = r_expr.data_b;
  assign bus.operation   = r_expr.operation;

endmodule

// File: tb/tb_expression_parser.sv
// Directed bench for expression_parser: byte streams with hand-computed results.
module tb_expression_parser;

  logic clock;
  logic reset;
  int   checks    = 0;
  int   errors    = 0;
  int   n_op      = 0;
  int   n_err     = 0;
  int   both_seen = 0;
  int   base_op;
  int   base_err;

  expression_parser_if u_if ();

  expression_parser #(
    .MAX_DIGITS (3)
`ifdef EXPRESSION_PARSER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count result/error pulses away from the active edge
  always @(negedge clock) begin
    if (u_if.op_valid === 1'b1) n_op++;
    if (u_if.parse_error === 1'b1) n_err++;
    if ((u_if.op_valid === 1'b1) && (u_if.parse_error === 1'b1)) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte (rx_valid left high) and return on the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    while ((u_if.rx_ready !== 1'b1) && (n < 16)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 16) begin
      checks++;
      errors++;
      $error("FAIL rx_ready_stall: observed=0 expected=1 within 16 cycles");
    end
    @(negedge clock);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
    end
  endtask

  task automatic release_rx();
    u_if.rx_valid = 1'b0;
    u_if.rx_data  = 8'h00;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op);
    check({tag, "_data_a"}, 32'(u_if.data_a), 32'(a));
    check({tag, "_data_b"}, 32'(u_if.data_b), 32'(b));
    check({tag, "_operation"}, 32'(u_if.operation), 32'(op));
  endtask

  task automatic mark();
    base_op  = n_op;
    base_err = n_err;
  endtask

  task automatic check_pulses(input string tag, input int ops, input int errs);
    check({tag, "_op_pulses"}, 32'(n_op - base_op), 32'(ops));
    check({tag, "_err_pulses"}, 32'(n_err - base_err), 32'(errs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.rx_data  = 8'h00;
    u_if.rx_valid = 1'b0;
    reset         = 1'b0;
    settle(3);

    // Reset state
    check_result("reset", 8'd0, 8'd0, 8'h00);
    check("reset_op_valid", 32'(u_if.op_valid), 32'd0);
    check("reset_parse_error", 32'(u_if.parse_error), 32'd0);
    check("reset_rx_ready", 32'(u_if.rx_ready), 32'd1);
    check("reset_busy", 32'(u_if.busy), 32'd0);
    reset = 1'b1;
    settle(2);

    // "12+34=" with rx_valid held high; op_valid in the cycle after '='
    mark();
    send_str("12+34=");
    check("t1_op_valid_n1", 32'(u_if.op_valid), 32'd1);
    check("t1_rx_ready_n1", 32'(u_if.rx_ready), 32'd0);
    check("t1_parse_error_n1", 32'(u_if.parse_error), 32'd0);
    check_result("t1", 8'd12, 8'd34, 8'h2B);
    release_rx();
    settle(1);
    check("t1_op_valid_n2", 32'(u_if.op_valid), 32'd0);
    check("t1_rx_ready_n2", 32'(u_if.rx_ready), 32'd1);
    check("t1_busy_n2", 32'(u_if.busy), 32'd0);
    settle(2);
    check_pulses("t1", 1, 0);

    // Spaces and CR terminator, operand at upper bound
    mark();
    send_str(" 255 * 1 ");
    send_byte(8'h0D);
    release_rx();
    settle(3);
    check_pulses("t2", 1, 0);
    check_result("t2", 8'd255, 8'd1, 8'h2A);

    // "256" errors at the '6'; rest flushed; outputs keep previous values
    mark();
    send_str("25");
    send_byte("6");
    check("t3_parse_error_at_6", 32'(u_if.parse_error), 32'd1);
    check("t3_busy_flush", 32'(u_if.busy), 32'd1);
    send_str("+1=");
    release_rx();
    settle(3);
    check_pulses("t3", 0, 1);
    check_result("t3_hold", 8'd255, 8'd1, 8'h2A);
    check("t3_busy_end", 32'(u_if.busy), 32'd0);

    // Digit-count limit: four digits fail, three leading-zero digits pass
    mark();
    send_str("0007+1=");
    release_rx();
    settle(3);
    check_pulses("t4a", 0, 1);
    mark();
    send_str("007+1=");
    release_rx();
    settle(3);
    check_pulses("t4b", 1, 0);
    check_result("t4b", 8'd7, 8'd1, 8'h2B);

    // Terminator as the error byte returns straight to IDLE
    mark();
    send_str("7+=");
    check("t5_parse_error", 32'(u_if.parse_error), 32'd1);
    check("t5_busy_idle", 32'(u_if.busy), 32'd0);
    send_str("3|5=");
    release_rx();
    settle(3);
    check_pulses("t5", 1, 1);
    check_result("t5", 8'd3, 8'd5, 8'h7C);

    // Empty line is ignored; invalid byte in IDLE errors and flushes
    mark();
    send_str("=");
    release_rx();
    settle(2);
    check_pulses("t6a", 0, 0);
    mark();
    send_str("x5=");
    release_rx();
    settle(3);
    check_pulses("t6b", 0, 1);
    check("t6b_busy", 32'(u_if.busy), 32'd0);

    // Reset mid-expression discards the partial parse
    send_str("9-");
    release_rx();
    settle(1);
    check("t7_busy_mid", 32'(u_if.busy), 32'd1);
    reset = 1'b0;
    settle(1);
    check_result("t7_reset", 8'd0, 8'd0, 8'h00);
    check("t7_busy_reset", 32'(u_if.busy), 32'd0);
    check("t7_rx_ready_reset", 32'(u_if.rx_ready), 32'd1);
    reset = 1'b1;
    settle(2);
    mark();
    send_str("8/2=");
    release_rx();
    settle(3);
    check_pulses("t7", 1, 0);
    check_result("t7", 8'd8, 8'd2, 8'h2F);

`ifdef EXPRESSION_PARSER_TIMEOUT_EN
    // Stall after the operator: error pulse after 100 idle cycles, back to IDLE
    mark();
    send_str("4&");
    release_rx();
    settle(90);
    check_pulses("t8_early", 0, 0);
    check("t8_busy_early", 32'(u_if.busy), 32'd1);
    settle(15);
    check_pulses("t8_late", 0, 1);
    check("t8_busy_late", 32'(u_if.busy), 32'd0);
    mark();
    send_str("4&6=");
    release_rx();
    settle(3);
    check_pulses("t8", 1, 0);
    check_result("t8", 8'd4, 8'd6, 8'h26);
`endif

    check("never_both_pulses", 32'(both_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
